// File: rtl/tilelink_pkg.sv
// tilelink_pkg: TileLink-UL/UH opcodes, arbiter state type and beat helpers
package tilelink_pkg;

    localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
    localparam logic [2:0] TL_A_ARITH         = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL       = 3'd3;
    localparam logic [2:0] TL_A_GET           = 3'd4;
    localparam logic [2:0] TL_A_INTENT        = 3'd5;
    localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;
    localparam logic [2:0] TL_D_HINTACK       = 3'd2;

    localparam int TL_CNT_W    = 16;
    localparam int TL_MAX_SIZE = 15;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    function automatic logic tl_has_data(input logic [2:0] opcode);
        return opcode inside {TL_A_PUTFULL, TL_A_PUTPARTIAL, TL_A_ARITH, TL_A_LOGICAL};
    endfunction

    // Sizes of 2^15 bytes and above saturate so the count always fits 16 bits
    function automatic logic [TL_CNT_W-1:0] tl_beats(input logic [3:0] size, input int log2_bb);
        int s;
        s = (size >= 4'(TL_MAX_SIZE)) ? TL_MAX_SIZE : int'(size);
        return (s > log2_bb) ? TL_CNT_W'(1 << (s - log2_bb)) : TL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tilelink_rr_lock.sv
// tilelink_rr_lock: round-robin grant with lock held across multi-beat A messages
module tilelink_rr_lock
    import tilelink_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic                fire,
    input  logic [TL_CNT_W-1:0] beats,
    output logic                grant
);

    arb_state_e          state;
    logic                owner;
    logic                prio;
    logic [TL_CNT_W-1:0] cnt;

    assign grant = (state == ARB_LOCKED) ? owner : (&req) ? prio : req[1];

    // Lock on the first beat of a burst, count beats down, flip priority on every last beat
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
        end else if (fire) begin
            if (state == ARB_IDLE) begin
                if (beats > TL_CNT_W'(1)) begin
                    state <= ARB_LOCKED;
                    owner <= grant;
                    cnt   <= beats - TL_CNT_W'(1);
                end else begin
                    prio <= ~grant;
                end
            end else begin
                cnt <= cnt - TL_CNT_W'(1);
                if (cnt == TL_CNT_W'(1)) begin
                    state <= ARB_IDLE;
                    prio  <= ~grant;
                end
            end
        end
    end

endmodule

// File: rtl/tilelink_ad_arbiter.sv
// tilelink_ad_arbiter: two-master, one-slave TileLink A/D arbiter with source-tag D routing
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
module tilelink_ad_arbiter
    import tilelink_pkg::*;
#(
    parameter  int XLEN   = `RISCV_FORMAL_XLEN,
    parameter  int ADDR_W = 32,
    parameter  int SRC_W  = 1,
    localparam int BB     = XLEN / 8
) (
    input  logic              clock,
    input  logic              reset,

    output logic              m0_a_ready,
    input  logic              m0_a_valid,
    input  logic [2:0]        m0_a_bits_opcode,
    input  logic [2:0]        m0_a_bits_param,
    input  logic [3:0]        m0_a_bits_size,
    input  logic [SRC_W-1:0]  m0_a_bits_source,
    input  logic [ADDR_W-1:0] m0_a_bits_address,
    input  logic [BB-1:0]     m0_a_bits_mask,
    input  logic [XLEN-1:0]   m0_a_bits_data,
    input  logic              m0_d_ready,
    output logic              m0_d_valid,
    output logic [2:0]        m0_d_bits_opcode,
    output logic [1:0]        m0_d_bits_param,
    output logic [3:0]        m0_d_bits_size,
    output logic [SRC_W-1:0]  m0_d_bits_source,
    output logic              m0_d_bits_sink,
    output logic [XLEN-1:0]   m0_d_bits_data,
    output logic              m0_d_bits_error,

    output logic              m1_a_ready,
    input  logic              m1_a_valid,
    input  logic [2:0]        m1_a_bits_opcode,
    input  logic [2:0]        m1_a_bits_param,
    input  logic [3:0]        m1_a_bits_size,
    input  logic [SRC_W-1:0]  m1_a_bits_source,
    input  logic [ADDR_W-1:0] m1_a_bits_address,
    input  logic [BB-1:0]     m1_a_bits_mask,
    input  logic [XLEN-1:0]   m1_a_bits_data,
    input  logic              m1_d_ready,
    output logic              m1_d_valid,
    output logic [2:0]        m1_d_bits_opcode,
    output logic [1:0]        m1_d_bits_param,
    output logic [3:0]        m1_d_bits_size,
    output logic [SRC_W-1:0]  m1_d_bits_source,
    output logic              m1_d_bits_sink,
    output logic [XLEN-1:0]   m1_d_bits_data,
    output logic              m1_d_bits_error,

    input  logic              s_a_ready,
    output logic              s_a_valid,
    output logic [2:0]        s_a_bits_opcode,
    output logic [2:0]        s_a_bits_param,
    output logic [3:0]        s_a_bits_size,
    output logic [SRC_W:0]    s_a_bits_source,
    output logic [ADDR_W-1:0] s_a_bits_address,
    output logic [BB-1:0]     s_a_bits_mask,
    output logic [XLEN-1:0]   s_a_bits_data,
    output logic              s_d_ready,
    input  logic              s_d_valid,
    input  logic [2:0]        s_d_bits_opcode,
    input  logic [1:0]        s_d_bits_param,
    input  logic [3:0]        s_d_bits_size,
    input  logic [SRC_W:0]    s_d_bits_source,
    input  logic              s_d_bits_sink,
    input  logic [XLEN-1:0]   s_d_bits_data,
    input  logic              s_d_bits_error
);

    localparam int LOG2BB = $clog2(BB);

    logic                grant;
    logic                a_fire;
    logic                d_idx;
    logic [TL_CNT_W-1:0] a_beats;

    assign s_a_valid        = !reset && (grant ? m1_a_valid : m0_a_valid);
    assign s_a_bits_opcode  = grant ? m1_a_bits_opcode  : m0_a_bits_opcode;
    assign s_a_bits_param   = grant ? m1_a_bits_param   : m0_a_bits_param;
    assign s_a_bits_size    = grant ? m1_a_bits_size    : m0_a_bits_size;
    assign s_a_bits_source  = {grant, grant ? m1_a_bits_source : m0_a_bits_source};
    assign s_a_bits_address = grant ? m1_a_bits_address : m0_a_bits_address;
    assign s_a_bits_mask    = grant ? m1_a_bits_mask    : m0_a_bits_mask;
    assign s_a_bits_data    = grant ? m1_a_bits_data    : m0_a_bits_data;
    assign m0_a_ready       = !reset && !grant && s_a_ready;
    assign m1_a_ready       = !reset && grant && s_a_ready;

    assign a_fire  = s_a_valid && s_a_ready;
    assign a_beats = tl_has_data(s_a_bits_opcode) ? tl_beats(s_a_bits_size, LOG2BB) : TL_CNT_W'(1);

    tilelink_rr_lock u_lock (
        .clock (clock),
        .reset (reset),
        .req   ({m1_a_valid, m0_a_valid}),
        .fire  (a_fire),
        .beats (a_beats),
        .grant (grant)
    );

    // D payload is broadcast; only valid and ready follow the source tag bit
    assign d_idx      = s_d_bits_source[SRC_W];
    assign m0_d_valid = !reset && s_d_valid && !d_idx;
    assign m1_d_valid = !reset && s_d_valid && d_idx;
    assign s_d_ready  = !reset && (d_idx ? m1_d_ready : m0_d_ready);

    assign m0_d_bits_opcode = s_d_bits_opcode;
    assign m0_d_bits_param  = s_d_bits_param;
    assign m0_d_bits_size   = s_d_bits_size;
    assign m0_d_bits_source = s_d_bits_source[SRC_W-1:0];
    assign m0_d_bits_sink   = s_d_bits_sink;
    assign m0_d_bits_data   = s_d_bits_data;
    assign m0_d_bits_error  = s_d_bits_error;
    assign m1_d_bits_opcode = s_d_bits_opcode;
    assign m1_d_bits_param  = s_d_bits_param;
    assign m1_d_bits_size   = s_d_bits_size;
    assign m1_d_bits_source = s_d_bits_source[SRC_W-1:0];
    assign m1_d_bits_sink   = s_d_bits_sink;
    assign m1_d_bits_data   = s_d_bits_data;
    assign m1_d_bits_error  = s_d_bits_error;

endmodule

// File: doc/tilelink_ad_arbiter.md
# tilelink_ad_arbiter

Two-master, one-slave TileLink-UL/UH A/D channel arbiter for the formal harness. It lets two TileLink masters share a single A/D slave, such as the dummy memory responder, without protocol violations. Typical masters are the tile master port and a debug/DMA stimulus port. A-channel grants are round-robin and locked across multi-beat data messages. D-channel beats are routed back to their master by a tag bit appended to the source field.

## Interface
Parameters:
- XLEN, default `RISCV_FORMAL_XLEN`: data width; beat bytes BB = XLEN/8.
- ADDR_W, default 32: address width.
- SRC_W, default 1: upstream source width; downstream source width is SRC_W+1.

Ports. mN means m0 and m1, one identical set each.
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- mN_a_ready  output  1  A accept to master N.
- mN_a_valid  input  1  A valid from master N.
- mN_a_bits_{opcode,param,size,source,address,mask,data}  input  3/3/4/SRC_W/ADDR_W/BB/XLEN  A payload.
- mN_d_ready  input  1  master N accepts D.
- mN_d_valid  output  1  D valid to master N.
- mN_d_bits_{opcode,param,size,source,sink,data,error}  output  3/2/4/SRC_W/1/XLEN/1  D payload.
- s_a_ready  input  1; s_a_valid  output  1; s_a_bits_*  output  same widths, except source is SRC_W+1.
- s_d_ready  output  1; s_d_valid  input  1; s_d_bits_*  input  same widths, except source is SRC_W+1.

## Operation
- A data-carrying message has an A opcode of PutFullData (0), PutPartialData (1), ArithmeticData (2) or LogicalData (3).
- A-message beat count:
  - data-carrying and size > log2(BB): 2^(size - log2 BB);
  - otherwise: 1.
- A arbiter states: IDLE and LOCKED(owner).
- IDLE:
  - grant = the requesting master if only one is valid;
  - if both are valid, grant = the master indicated by prio.
- LOCKED: grant = owner; the other master's a_ready = 0.
- Routing:
  - s_a_valid = granted valid.
  - s_a_bits = granted payload, with s_a_bits_source = {grant, mN_a_bits_source}.
  - granted mN_a_ready = s_a_ready; the other master's a_ready = 0.
- Transitions:
  - IDLE -> LOCKED(grant) when the first beat of a multi-beat message fires; beat counter loads beats-1.
  - In LOCKED, each fire decrements the counter; counter 1 -> 0 on a fire returns to IDLE.
- Priority: on the last beat of any message, prio <= ~grant. Single-beat messages count as last.
- D routing is stateless:
  - idx = s_d_bits_source[SRC_W];
  - m{idx}_d_valid = s_d_valid; the other master's d_valid = 0;
  - s_d_ready = m{idx}_d_ready;
  - mN_d_bits = s_d_bits with source[SRC_W-1:0]; the payload is broadcast to both masters and only valid is gated.
- Reset:
  - state IDLE, counter 0, prio 0;
  - while reset is high, all *_valid and *_ready outputs are forced 0.
  - Reset mid-burst abandons the lock.

## Timing
- Zero-cycle combinational path A->A and D->D; no registers on payload.
- State (lock, owner, counter, prio) updates on the posedge after a fire (valid && ready).
- Grant in IDLE is recomputed every cycle until fire. A valid master whose request is not yet accepted may lose grant only if it was never ready. It holds valid per TileLink rules, and round-robin guarantees it service within one message of the other master.
- Simultaneous A fire and D fire are independent; D never stalls A.
- Counter width is 16 bits; max beats is 2^15/BB.
- size field values >= 15 are treated as 2^15 bytes.

## Structure
- Shared package `tilelink_pkg`:
  - A/D opcode localparams: get=4, putfull=0, putpartial=1, arith=2, logical=3, intent=5, accessack=0, accessackdata=1, hintack=2;
  - function `tl_has_data(opcode)`;
  - function `tl_beats(size, log2_bb)`.
- One sub-module: `tilelink_rr_lock`. It holds the IDLE/LOCKED state, owner, beat counter and prio, and outputs grant. Muxing stays in the top module.

## Test plan
- Only m0 issues Get size=2 source=1 -> s_a_bits_source=2'b01; m1_a_ready=0; a D beat with source=2'b01 reaches m0 only, with source=1.
- Both masters issue single-beat Gets every cycle, s_a_ready=1 -> grants alternate m0, m1, m0, m1 starting from m0 after reset.
- m1 PutFullData size=4 with BB=4 (4 beats) while m0 holds a Get -> four consecutive m1 beats, then m0 is granted; m0_a_ready stays 0 during the burst.
- s_a_ready toggles 1,0,1,0 during a 4-beat put -> the lock holds; IDLE is reached only after the 4th fire; prio then points to m0.
- D beat with source MSB=1 and m1_d_ready=0 -> s_d_ready=0 and m0_d_valid=0; in the same cycle m0's A request still fires.
- Reset asserted after beat 2 of a 4-beat put -> next cycle all valid/ready outputs are 0; after reset deasserts, state is IDLE and m0 has priority.
